rmii_rx_ring: RTL and testbench
===============================

# rmii_rx_ring

Parametrised RMII receive front end for the Ethernet framing subsystem, running entirely in the clk_rmii domain. It synchronises to the preamble/SFD, assembles dibits into bytes, and writes each frame into one of NBUF fixed-size slots of an external byte-wide dual-port RAM. Completed frames are handed to the host through a descriptor valid/ready handshake, and slots are returned by an explicit release pulse. Unlike the single-buffer capture path, it can queue back-to-back frames, drops frames cleanly when no slot is free, and reports runt, truncation and error status per frame.

## Interface
- NBUF, 4: number of frame slots; power of two, 2..16.
- BUF_AW, 11: log2 of slot size in bytes; slot holds 2^BUF_AW bytes.
- MIN_LEN, 60: frames with fewer bytes are runts and are discarded.
- Derived: BW = log2(NBUF).

- clk_rmii  in  1  RMII reference clock, 50 MHz.
- rstn  in  1  synchronous, active-low reset.
- rxd  in  2  RMII receive dibit, LSB-first.
- crs_dv  in  1  receive data valid (treated as pure DV).
- rx_er  in  1  PHY receive error.
- enable  in  1  accept new frames; sampled only in IDLE.
- wr_en  out  1  RAM byte write strobe.
- wr_addr  out  BW+BUF_AW  RAM byte address {slot, byte_idx}.
- wr_data  out  8  RAM byte data.
- desc_valid  out  1  committed descriptor available.
- desc_ready  in  1  host accepts the descriptor.
- desc_slot  out  BW  slot index of the head descriptor.
- desc_len  out  BUF_AW+1  bytes stored for the frame.
- desc_stat  out  3  {rx_er_seen, align_err, truncated}.
- release  in  1  one-cycle pulse that frees the oldest host-owned slot.
- free_cnt  out  BW+1  slots available for filling.
- drop_cnt  out  16  saturating count of frames dropped.
- busy  out  1  FSM not in IDLE.

## Operation
- rxd, crs_dv and rx_er are registered once (the _q copies); all FSM decisions use the _q values.
- Pointers are each BW+1 bits: fill_ptr, head_ptr, rel_ptr. free_cnt = NBUF - (fill_ptr - rel_ptr). Committed count = fill_ptr - head_ptr.
- FSM states:
  - IDLE: if dv_q=1, rxd_q=01, enable=1 and free_cnt>0, go to PRE with pre_cnt=1. If the same condition holds but free_cnt=0 or enable=0, go to DROP and increment drop_cnt. If dv_q=1 with rxd_q=00, stay in IDLE.
  - PRE: on rxd_q=01, increment pre_cnt (saturates at 3). On rxd_q=11 with pre_cnt>=2, go to DATA with byte_idx=0 and phase=0. On any other dibit, or dv_q=0, go to DROP/IDLE and increment drop_cnt.
  - DATA: on each dv_q=1 cycle, shift the dibit into the byte in LSB-first order: byte = {d3,d2,d1,d0}, and increment phase.
    - At phase 3, issue a write of byte at {fill_ptr[BW-1:0], byte_idx}, then increment byte_idx.
    - Once 2^BUF_AW bytes are written, set truncated, suppress further writes and keep counting nothing.
    - rx_er_q=1 at any point sets rx_er_seen.
    - On dv_q=0 go to IDLE. If phase≠0, set align_err and discard the partial byte.
    - If len < MIN_LEN, discard: fill_ptr unchanged, drop_cnt++.
    - Otherwise commit: store len and stat in the slot's descriptor register, then fill_ptr++.
  - DROP: hold until dv_q=0, then go to IDLE. No writes.
- Descriptor handshake: desc_valid = (fill_ptr != head_ptr). desc_slot, desc_len and desc_stat show the head slot's registers. When desc_valid & desc_ready, head_ptr++.
- release: if head_ptr != rel_ptr, rel_ptr++. Otherwise ignore it.
- Simultaneous commit, pop and release in one cycle all take effect; the pointer updates are independent.
- drop_cnt saturates at 0xFFFF.
- Reset mid-frame: every pointer, counter and register clears, and any partial frame is lost.

## Timing
- Reset values:
  - wr_en=0, wr_addr=0, wr_data=0
  - desc_valid=0, desc_slot=0, desc_len=0, desc_stat=0
  - free_cnt=NBUF, drop_cnt=0, busy=0
- Write latency: wr_en pulses for one cycle, 2 cycles after the 4th dibit of a byte appears at the pins (input register plus output register). Writes for consecutive bytes are 4 cycles apart.
- Commit latency: if crs_dv is low at the pins in cycle t, desc_valid is high at t+2 and free_cnt has decremented by then.
- desc_valid and its data are registered. When desc_ready is held high, one descriptor pops per cycle.
- The release effect appears on free_cnt the next cycle.
- Back-to-back frames: a new preamble is accepted in the cycle after IDLE is re-entered.

## Test plan
- Frame with 7×01 preamble, SFD 11, then 64 bytes 0x00..0x3F: 64 wr_en pulses at addresses 0..63 with matching data; desc_valid at t+2 after DV falls; desc_slot=0, desc_len=64, desc_stat=0, free_cnt=3.
- Four 64-byte frames with no pop or release, then a fifth frame: slots 0..3 commit, free_cnt=0; the fifth frame causes no writes and drop_cnt=1. Then pop and release once: free_cnt=1, and a sixth frame lands in slot 0.
- 40-byte frame: discarded, drop_cnt=1, desc_valid stays 0, free_cnt=4.
- 2100-byte frame with BUF_AW=11: exactly 2048 writes; desc_len=2048, truncated=1.
- 100-byte frame with rx_er high for one mid-frame cycle, then DV falling after an odd dibit: desc_len=100, desc_stat=3'b110.
- rstn asserted during byte 30 of a frame: all outputs return to their reset values next cycle, and a following frame lands in slot 0.

Source files
------------

// File: rtl/rmii_rx_ring.sv
// RMII receive front end: preamble/SFD sync, dibit-to-byte assembly and
// a ring of NBUF frame slots handed to the host via descriptors.
module rmii_rx_ring #(
   parameter int NBUF    = 4,
   parameter int BUF_AW  = 11,
   parameter int MIN_LEN = 60,
   localparam int BW     = $clog2(NBUF)
) (
   input  logic                 clk_rmii,
   input  logic                 rstn,
   input  logic [1:0]           rxd,
   input  logic                 crs_dv,
   input  logic                 rx_er,
   input  logic                 enable,
   output logic                 wr_en,
   output logic [BW+BUF_AW-1:0] wr_addr,
   output logic [7:0]           wr_data,
   output logic                 desc_valid,
   input  logic                 desc_ready,
   output logic [BW-1:0]        desc_slot,
   output logic [BUF_AW:0]      desc_len,
   output logic [2:0]           desc_stat,
   input  logic                 slot_release,
   output logic [BW:0]          free_cnt,
   output logic [15:0]          drop_cnt,
   output logic                 busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRE,
      S_DATA,
      S_DROP
   } state_t;

   localparam logic [BW:0]     NBUF_W = (BW+1)'(NBUF);
   localparam logic [BW:0]     PTR1   = (BW+1)'(1);
   localparam logic [BUF_AW:0] IDX1   = (BUF_AW+1)'(1);
   localparam logic [BUF_AW:0] FULL   = {1'b1, {BUF_AW{1'b0}}};
   localparam logic [BUF_AW:0] MIN_W  = (BUF_AW+1)'(MIN_LEN);

   state_t          state;
   logic [1:0]      rxd_q;
   logic            dv_q;
   logic            er_q;
   logic [BW:0]     fill_ptr;
   logic [BW:0]     head_ptr;
   logic [BW:0]     rel_ptr;
   logic [1:0]      pre_cnt;
   logic [1:0]      phase;
   logic [5:0]      sh;
   logic [BUF_AW:0] byte_idx;
   logic            trunc;
   logic            er_seen;
   logic [BUF_AW:0] len_r  [NBUF];
   logic [2:0]      stat_r [NBUF];
   logic [15:0]     drop_sat;
   logic            pop;
   logic            rel;

   assign free_cnt   = NBUF_W - (fill_ptr - rel_ptr);
   assign desc_valid = (fill_ptr != head_ptr);
   assign desc_slot  = head_ptr[BW-1:0];
   assign desc_len   = len_r[head_ptr[BW-1:0]];
   assign desc_stat  = stat_r[head_ptr[BW-1:0]];
   assign busy       = (state != S_IDLE);
   assign pop        = desc_valid & desc_ready;
   assign rel        = slot_release & (head_ptr != rel_ptr);
   assign drop_sat   = (drop_cnt == 16'hFFFF) ? drop_cnt
                                              : drop_cnt + 16'd1;

   always_ff @(posedge clk_rmii) begin
      if (!rstn) begin
         rxd_q    <= '0;
         dv_q     <= 1'b0;
         er_q     <= 1'b0;
         state    <= S_IDLE;
         fill_ptr <= '0;
         head_ptr <= '0;
         rel_ptr  <= '0;
         pre_cnt  <= '0;
         phase    <= '0;
         sh       <= '0;
         byte_idx <= '0;
         trunc    <= 1'b0;
         er_seen  <= 1'b0;
         drop_cnt <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         for (int i = 0; i < NBUF; i++) begin
            len_r[i]  <= '0;
            stat_r[i] <= '0;
         end
      end else begin
         rxd_q <= rxd;
         dv_q  <= crs_dv;
         er_q  <= rx_er;
         wr_en <= 1'b0;
         if (pop) head_ptr <= head_ptr + PTR1;
         if (rel) rel_ptr <= rel_ptr + PTR1;
         unique case (state)
            S_IDLE: begin
               if (dv_q && rxd_q == 2'b01) begin
                  if (enable && free_cnt != '0) begin
                     state   <= S_PRE;
                     pre_cnt <= 2'd1;
                  end else begin
                     state    <= S_DROP;
                     drop_cnt <= drop_sat;
                  end
               end
            end
            S_PRE: begin
               if (!dv_q) begin
                  state    <= S_IDLE;
                  drop_cnt <= drop_sat;
               end else if (rxd_q == 2'b01) begin
                  if (pre_cnt != 2'd3) pre_cnt <= pre_cnt + 2'd1;
               end else if (rxd_q == 2'b11 && pre_cnt >= 2'd2) begin
                  state    <= S_DATA;
                  byte_idx <= '0;
                  phase    <= '0;
                  trunc    <= 1'b0;
                  er_seen  <= 1'b0;
               end else begin
                  state    <= S_DROP;
                  drop_cnt <= drop_sat;
               end
            end
            S_DATA: begin
               if (dv_q) begin
                  sh    <= {rxd_q, sh[5:2]};
                  phase <= phase + 2'd1;
                  if (er_q) er_seen <= 1'b1;
                  // Bytes past the end of the slot are counted as truncation only
                  if (phase == 2'd3) begin
                     if (byte_idx == FULL) begin
                        trunc <= 1'b1;
                     end else begin
                        wr_en    <= 1'b1;
                        wr_addr  <= {fill_ptr[BW-1:0],
                                     byte_idx[BUF_AW-1:0]};
                        wr_data  <= {rxd_q, sh};
                        byte_idx <= byte_idx + IDX1;
                     end
                  end
               end else begin
                  state <= S_IDLE;
                  if (byte_idx < MIN_W) begin
                     drop_cnt <= drop_sat;
                  end else begin
                     len_r[fill_ptr[BW-1:0]]  <= byte_idx;
                     stat_r[fill_ptr[BW-1:0]] <= {er_seen | er_q,
                                                  phase != 2'd0,
                                                  trunc};
                     fill_ptr <= fill_ptr + PTR1;
                  end
               end
            end
            S_DROP: begin
               if (!dv_q) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rmii_rx_ring.sv
// Directed bench for rmii_rx_ring: framing, slot ring, drops,
// truncation, status bits and mid-frame reset.
`timescale 1ns/1ps
module tb_rmii_rx_ring;

   logic        clk_rmii;
   logic        rstn;
   logic [1:0]  rxd;
   logic        crs_dv;
   logic        rx_er;
   logic        enable;
   logic        wr_en;
   logic [12:0] wr_addr;
   logic [7:0]  wr_data;
   logic        desc_valid;
   logic        desc_ready;
   logic [1:0]  desc_slot;
   logic [11:0] desc_len;
   logic [2:0]  desc_stat;
   logic        slot_release;
   logic [2:0]  free_cnt;
   logic [15:0] drop_cnt;
   logic        busy;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int t_b0  = 0;

   logic [31:0] wq_addr [$];
   logic [31:0] wq_data [$];
   int          wq_cyc  [$];

   rmii_rx_ring dut (
      .clk_rmii     (clk_rmii),
      .rstn         (rstn),
      .rxd          (rxd),
      .crs_dv       (crs_dv),
      .rx_er        (rx_er),
      .enable       (enable),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .desc_valid   (desc_valid),
      .desc_ready   (desc_ready),
      .desc_slot    (desc_slot),
      .desc_len     (desc_len),
      .desc_stat    (desc_stat),
      .slot_release (slot_release),
      .free_cnt     (free_cnt),
      .drop_cnt     (drop_cnt),
      .busy         (busy)
   );

   initial clk_rmii = 1'b0;
   always #10 clk_rmii = ~clk_rmii;

   always @(posedge clk_rmii) cyc <= cyc + 1;

   always @(negedge clk_rmii) begin
      if (wr_en) begin
         wq_addr.push_back(32'(wr_addr));
         wq_data.push_back(32'(wr_data));
         wq_cyc.push_back(cyc);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] qa(input int i);
      return (i < wq_addr.size()) ? wq_addr[i] : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] qd(input int i);
      return (i < wq_data.size()) ? wq_data[i] : 32'hFFFF_FFFF;
   endfunction

   function automatic int qc(input int i);
      return (i < wq_cyc.size()) ? wq_cyc[i] : -1000;
   endfunction

   task automatic wq_clear();
      wq_addr.delete();
      wq_data.delete();
      wq_cyc.delete();
   endtask

   task automatic drive(input logic [1:0] d, input logic dv,
                        input logic er);
      rxd    = d;
      crs_dv = dv;
      rx_er  = er;
      @(negedge clk_rmii);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(2'b00, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rstn         = 1'b0;
      rxd          = 2'b00;
      crs_dv       = 1'b0;
      rx_er        = 1'b0;
      desc_ready   = 1'b0;
      slot_release = 1'b0;
      repeat (2) @(negedge clk_rmii);
      rstn = 1'b1;
      @(negedge clk_rmii);
      wq_clear();
   endtask

   // Returns one cycle after crs_dv drops at the pins.
   task automatic send_frame(input int nbytes, input int extra,
                             input int er_at, input int abort_at);
      logic [7:0] b8;
      int         di;
      di = 0;
      for (int i = 0; i < 7; i++) drive(2'b01, 1'b1, 1'b0);
      drive(2'b11, 1'b1, 1'b0);
      for (int b = 0; b < nbytes; b++) begin
         b8 = b[7:0];
         for (int k = 0; k < 4; k++) begin
            if (b == abort_at) begin
               rstn   = 1'b0;
               crs_dv = 1'b0;
               rxd    = 2'b00;
               rx_er  = 1'b0;
               @(negedge clk_rmii);
               return;
            end
            if (b == 0 && k == 3) t_b0 = cyc;
            drive(b8[2*k +: 2], 1'b1, di == er_at);
            di++;
         end
      end
      for (int i = 0; i < extra; i++) drive(2'b01, 1'b1, 1'b0);
      drive(2'b00, 1'b0, 1'b0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " wr_en"}, 32'(wr_en), 0);
      chk({tag, " wr_addr"}, 32'(wr_addr), 0);
      chk({tag, " wr_data"}, 32'(wr_data), 0);
      chk({tag, " desc_valid"}, 32'(desc_valid), 0);
      chk({tag, " desc_slot"}, 32'(desc_slot), 0);
      chk({tag, " desc_len"}, 32'(desc_len), 0);
      chk({tag, " desc_stat"}, 32'(desc_stat), 0);
      chk({tag, " free_cnt"}, 32'(free_cnt), 4);
      chk({tag, " drop_cnt"}, 32'(drop_cnt), 0);
      chk({tag, " busy"}, 32'(busy), 0);
   endtask

   initial begin
      rstn         = 1'b0;
      rxd          = 2'b00;
      crs_dv       = 1'b0;
      rx_er        = 1'b0;
      enable       = 1'b1;
      desc_ready   = 1'b0;
      slot_release = 1'b0;
      repeat (3) @(negedge clk_rmii);
      check_reset("rst");
      rstn = 1'b1;
      @(negedge clk_rmii);

      // single 64-byte frame
      wq_clear();
      send_frame(64, 0, -1, -1);
      chk("t1 valid_t1", 32'(desc_valid), 0);
      @(negedge clk_rmii);
      chk("t1 valid_t2", 32'(desc_valid), 1);
      chk("t1 free_t2", 32'(free_cnt), 3);
      chk("t1 busy", 32'(busy), 0);
      chk("t1 nwr", wq_addr.size(), 64);
      for (int i = 0; i < 64; i++) begin
         chk("t1 addr", qa(i), i);
         chk("t1 data", qd(i), i);
      end
      chk("t1 wlat", qc(0) - t_b0, 2);
      chk("t1 wgap", qc(1) - qc(0), 4);
      chk("t1 slot", 32'(desc_slot), 0);
      chk("t1 len", 32'(desc_len), 64);
      chk("t1 stat", 32'(desc_stat), 0);

      // fill all slots, drop, pop/release, reuse slot 0
      do_reset();
      for (int f = 0; f < 4; f++) begin
         send_frame(64, 0, -1, -1);
         idle(3);
      end
      chk("t2 nwr", wq_addr.size(), 256);
      for (int f = 0; f < 4; f++) chk("t2 base", qa(64*f), f << 11);
      chk("t2 free", 32'(free_cnt), 0);
      chk("t2 valid", 32'(desc_valid), 1);
      chk("t2 head", 32'(desc_slot), 0);
      wq_clear();
      send_frame(64, 0, -1, -1);
      idle(3);
      chk("t2 drop_nwr", wq_addr.size(), 0);
      chk("t2 drop_cnt", 32'(drop_cnt), 1);
      chk("t2 drop_busy", 32'(busy), 0);
      desc_ready = 1'b1;
      @(negedge clk_rmii);
      desc_ready   = 1'b0;
      slot_release = 1'b1;
      @(negedge clk_rmii);
      slot_release = 1'b0;
      chk("t2 free_rel", 32'(free_cnt), 1);
      chk("t2 head_pop", 32'(desc_slot), 1);
      wq_clear();
      send_frame(64, 0, -1, -1);
      idle(3);
      chk("t2 f6_nwr", wq_addr.size(), 64);
      chk("t2 f6_addr0", qa(0), 0);
      chk("t2 f6_addr63", qa(63), 63);
      chk("t2 f6_free", 32'(free_cnt), 0);
      chk("t2 f6_drop", 32'(drop_cnt), 1);

      // runt
      do_reset();
      send_frame(40, 0, -1, -1);
      idle(3);
      chk("t3 drop", 32'(drop_cnt), 1);
      chk("t3 valid", 32'(desc_valid), 0);
      chk("t3 free", 32'(free_cnt), 4);

      // oversize frame
      do_reset();
      send_frame(2100, 0, -1, -1);
      idle(3);
      chk("t4 nwr", wq_addr.size(), 2048);
      chk("t4 last_addr", qa(2047), 2047);
      chk("t4 last_data", qd(2047), 8'hFF);
      chk("t4 len", 32'(desc_len), 2048);
      chk("t4 stat", 32'(desc_stat), 3'b001);

      // rx_er mid-frame plus trailing odd dibit
      do_reset();
      send_frame(100, 1, 200, -1);
      idle(3);
      chk("t5 valid", 32'(desc_valid), 1);
      chk("t5 len", 32'(desc_len), 100);
      chk("t5 stat", 32'(desc_stat), 3'b110);

      // reset during byte 30 of the second frame
      do_reset();
      send_frame(64, 0, -1, -1);
      idle(3);
      chk("t6 pre_free", 32'(free_cnt), 3);
      send_frame(64, 0, -1, 30);
      check_reset("t6");
      rstn = 1'b1;
      idle(2);
      wq_clear();
      send_frame(64, 0, -1, -1);
      idle(3);
      chk("t6 addr0", qa(0), 0);
      chk("t6 valid", 32'(desc_valid), 1);
      chk("t6 slot", 32'(desc_slot), 0);
      chk("t6 len", 32'(desc_len), 64);
      chk("t6 free", 32'(free_cnt), 3);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
